// File: rtl/dm_abstract_cmd_if.sv
// DMI request/response lines and hart register port of the abstract-command block.
// slave = the abstract-command controller, master = the DMI / hart side.
interface dm_abstract_cmd_if;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_wdata;
  logic        dmi_write;
  logic        dmi_read;
  logic [31:0] dmi_rdata;
  logic        dmi_hit;
  logic        reg_req;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output dmi_address, dmi_wdata, dmi_write, dmi_read,
    input  dmi_rdata, dmi_hit,
    input  reg_req, reg_write, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );

  modport slave (
    input  dmi_address, dmi_wdata, dmi_write, dmi_read,
    output dmi_rdata, dmi_hit,
    output reg_req, reg_write, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );
endinterface

// File: rtl/dm_abstract_cmd.sv
// Debug-module abstract-command controller: abstractcs/command/data0 decode and one Access
// Register transfer at a time on the hart register port. DM_ABSTRACT_AUTOEXEC_EN adds abstractauto.
module dm_abstract_cmd #(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter logic [6:0]  ABSTRACTCS_ADDR = 7'h16,
  parameter logic [6:0]  COMMAND_ADDR    = 7'h17,
  parameter logic [6:0]  DATA0_ADDR      = 7'h04
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dmactive_i,
  input  logic             hart_halted_i,
  input  logic             hart_available_i,
  dm_abstract_cmd_if.slave bus
);
  localparam logic [0:0] IDLE         = 1'b0;
  localparam logic [0:0] ACCESS       = 1'b1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
`ifdef DM_ABSTRACT_AUTOEXEC_EN
  localparam logic [6:0] ABSTRACTAUTO_ADDR = 7'h18;
`endif

  logic [0:0]  state_q, state_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [31:0] data0_q, data0_d;
  logic        reg_req_q, reg_req_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic [7:0]  cnt_q, cnt_d;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
  logic        autoexec_q, autoexec_d;
  logic [30:0] cmd_q, cmd_d;
`endif

  logic        busy;
  logic        sel_acs, sel_cmd, sel_data0, sel_auto, sel_any;
  logic        exec;
  logic        cmd_bad;
  // Command word with reserved bit 23 dropped: [30:23]=cmdtype, [22:0] as in the command register.
  logic [30:0] exec_cmd;
  logic [31:0] exec_data;

  assign busy      = (state_q == ACCESS);
  assign sel_acs   = (bus.dmi_address == ABSTRACTCS_ADDR);
  assign sel_cmd   = (bus.dmi_address == COMMAND_ADDR);
  assign sel_data0 = (bus.dmi_address == DATA0_ADDR);
`ifdef DM_ABSTRACT_AUTOEXEC_EN
  assign sel_auto  = (bus.dmi_address == ABSTRACTAUTO_ADDR);
`else
  assign sel_auto  = 1'b0;
`endif
  assign sel_any   = sel_acs | sel_cmd | sel_data0 | sel_auto;

  always_comb begin
    state_d     = state_q;
    cmderr_d    = cmderr_q;
    data0_d     = data0_q;
    reg_req_d   = reg_req_q;
    reg_write_d = reg_write_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    cnt_d       = cnt_q;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
    autoexec_d  = autoexec_q;
    cmd_d       = cmd_q;
`endif
    exec      = 1'b0;
    cmd_bad   = 1'b0;
    exec_cmd  = {bus.dmi_wdata[31:24], bus.dmi_wdata[22:0]};
    exec_data = data0_q;

    if (busy) begin
      if (bus.dmi_write && sel_any && (cmderr_q == 3'd0)) begin
        cmderr_d = 3'd1;
      end
      // Ack wins over a same-cycle availability drop or timeout.
      if (bus.reg_ack) begin
        if (!reg_write_q) begin
          data0_d = bus.reg_rdata;
        end
        state_d   = IDLE;
        reg_req_d = 1'b0;
      end else if (!hart_available_i) begin
        state_d   = IDLE;
        reg_req_d = 1'b0;
        cmderr_d  = 3'd4;
      end else if (cnt_q == TIMEOUT_LAST) begin
        state_d   = IDLE;
        reg_req_d = 1'b0;
        cmderr_d  = 3'd7;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      if (bus.dmi_write && sel_acs) begin
        cmderr_d = cmderr_q & ~bus.dmi_wdata[10:8];
      end
      if (bus.dmi_write && sel_data0) begin
        data0_d = bus.dmi_wdata;
      end
      if (bus.dmi_write && sel_cmd && (cmderr_q == 3'd0)) begin
        exec = 1'b1;
      end
`ifdef DM_ABSTRACT_AUTOEXEC_EN
      if (exec) begin
        cmd_d = exec_cmd;
      end
      if (bus.dmi_write && sel_auto) begin
        autoexec_d = bus.dmi_wdata[0];
      end
      if ((bus.dmi_write || bus.dmi_read) && sel_data0 && (cmderr_q == 3'd0) && autoexec_q) begin
        exec      = 1'b1;
        exec_cmd  = cmd_q;
        exec_data = bus.dmi_write ? bus.dmi_wdata : data0_q;
      end
`endif
      // Only GPRs 0x1000..0x101F are reachable: regno[15:5] must equal 0x080.
      cmd_bad = (exec_cmd[30:23] != 8'd0) || (exec_cmd[22:20] != 3'd2) || exec_cmd[19] ||
                exec_cmd[18] || (exec_cmd[17] && (exec_cmd[15:5] != 11'h080));
      if (exec) begin
        if (cmd_bad) begin
          cmderr_d = 3'd2;
        end else if (!hart_halted_i || !hart_available_i) begin
          cmderr_d = 3'd4;
        end else if (exec_cmd[17]) begin
          state_d     = ACCESS;
          reg_req_d   = 1'b1;
          reg_write_d = exec_cmd[16];
          reg_addr_d  = exec_cmd[4:0];
          reg_wdata_d = exec_data;
          cnt_d       = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !dmactive_i) begin
      state_q     <= IDLE;
      cmderr_q    <= 3'd0;
      data0_q     <= 32'd0;
      reg_req_q   <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= 5'd0;
      reg_wdata_q <= 32'd0;
      cnt_q       <= 8'd0;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
      autoexec_q  <= 1'b0;
      cmd_q       <= 31'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmderr_q    <= cmderr_d;
      data0_q     <= data0_d;
      reg_req_q   <= reg_req_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      cnt_q       <= cnt_d;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
      autoexec_q  <= autoexec_d;
      cmd_q       <= cmd_d;
`endif
    end
  end

  always_comb begin
    bus.dmi_rdata = 32'd0;
    if (bus.dmi_read) begin
      if (sel_acs) begin
        bus.dmi_rdata = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1};
      end else if (sel_data0) begin
        bus.dmi_rdata = data0_q;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
      end else if (sel_auto) begin
        bus.dmi_rdata = {31'd0, autoexec_q};
`endif
      end
    end
  end

  assign bus.dmi_hit   = bus.dmi_read & sel_any;
  assign bus.reg_req   = reg_req_q;
  assign bus.reg_write = reg_write_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Bench for dm_abstract_cmd: directed vector table, hand sequences and random traffic
// against a transaction-level model of the abstract-command rules.
`timescale 1ns/1ps
module tb_dm_abstract_cmd;
  localparam int unsigned T = 4;
  localparam logic [6:0] ACS = 7'h16;
  localparam logic [6:0] CMD = 7'h17;
  localparam logic [6:0] D0  = 7'h04;
  localparam logic [6:0] AUT = 7'h18;

  typedef struct {
    logic        rstN, active, halted, avail;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        wr, rd, ack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expReq;
    logic [31:0] expRdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dmactive = 1'b0;
  logic hartHalted = 1'b1;
  logic hartAvailable = 1'b1;
  int   nPass = 0;
  int   nChecks = 0;

  // Reference model state: what the debugger should observe.
  bit          mBusy;
  logic [2:0]  mErr;
  logic [31:0] mData0, mWdata;
  logic        mWrite;
  logic [4:0]  mAddr;
  int          mAge;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
  logic        mAuto;
  logic [31:0] mCmd;
`endif

  dm_abstract_cmd_if bus();

  dm_abstract_cmd #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .dmactive_i(dmactive),
    .hart_halted_i(hartHalted), .hart_available_i(hartAvailable), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  function automatic void modelReset();
    mBusy = 0; mErr = 0; mData0 = 0; mWdata = 0; mWrite = 0; mAddr = 0; mAge = 0;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
    mAuto = 0; mCmd = 0;
`endif
  endfunction

  function automatic logic modelHit(input logic [6:0] a);
`ifdef DM_ABSTRACT_AUTOEXEC_EN
    if (a == AUT) return 1'b1;
`endif
    return (a == ACS) || (a == CMD) || (a == D0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [6:0] a);
    if (a == ACS) return (32'(mBusy) << 12) | (32'(mErr) << 8) | 32'd1;
    if (a == D0) return mData0;
`ifdef DM_ABSTRACT_AUTOEXEC_EN
    if (a == AUT) return 32'(mAuto);
`endif
    return 32'd0;
  endfunction

  function automatic void modelIssue(input logic [31:0] w, input logic [31:0] d, input logic halted, input logic avail);
    int unsigned cmdtype, size, regno;
    bit post, pexec, xfer;
    cmdtype = w >> 24;
    size    = (w >> 20) & 7;
    post    = ((w >> 19) & 1) != 0;
    pexec   = ((w >> 18) & 1) != 0;
    xfer    = ((w >> 17) & 1) != 0;
    regno   = w & 32'hFFFF;
    if (cmdtype != 0 || size != 2 || post || pexec || (xfer && (regno < 'h1000 || regno > 'h101F))) mErr = 3'd2;
    else if (!halted || !avail) mErr = 3'd4;
    else if (xfer) begin
      mBusy = 1; mWrite = ((w >> 16) & 1) != 0; mAddr = 5'(regno % 32); mWdata = d; mAge = 0;
    end
  endfunction

  function automatic void modelStep(input stim_t s);
    logic [2:0] errBefore;
    if (!s.rstN || !s.active) begin
      modelReset();
      return;
    end
    if (mBusy) begin
      if (s.wr && modelHit(s.addr) && mErr == 0) mErr = 3'd1;
      if (s.ack) begin
        if (!mWrite) mData0 = s.rdata;
        mBusy = 0;
      end else if (!s.avail) begin
        mErr = 3'd4; mBusy = 0;
      end else begin
        mAge++;
        if (mAge >= int'(T)) begin mErr = 3'd7; mBusy = 0; end
      end
    end else begin
      errBefore = mErr;
      if (s.wr && s.addr == ACS) mErr = mErr & ~s.wdata[10:8];
      if (s.wr && s.addr == D0) mData0 = s.wdata;
      if (s.wr && s.addr == CMD && errBefore == 0) begin
`ifdef DM_ABSTRACT_AUTOEXEC_EN
        mCmd = s.wdata;
`endif
        modelIssue(s.wdata, mData0, s.halted, s.avail);
      end
`ifdef DM_ABSTRACT_AUTOEXEC_EN
      if (s.wr && s.addr == AUT) mAuto = s.wdata[0];
      if ((s.wr || s.rd) && s.addr == D0 && errBefore == 0 && mAuto)
        modelIssue(mCmd, mData0, s.halted, s.avail);
`endif
    end
  endfunction

  task automatic applyStimulus(input stim_t s, output logic reqSeen, output logic [31:0] rdataSeen);
    @(negedge clk);
    reqSeen = bus.reg_req;
    checkOutput("reg_req", 32'(bus.reg_req), 32'(mBusy));
    if (mBusy) begin
      checkOutput("reg_write", 32'(bus.reg_write), 32'(mWrite));
      checkOutput("reg_addr", 32'(bus.reg_addr), 32'(mAddr));
      checkOutput("reg_wdata", bus.reg_wdata, mWdata);
    end
    rst_n = s.rstN; dmactive = s.active; hartHalted = s.halted; hartAvailable = s.avail;
    bus.dmi_address = s.addr; bus.dmi_wdata = s.wdata; bus.dmi_write = s.wr; bus.dmi_read = s.rd;
    bus.reg_ack = s.ack; bus.reg_rdata = s.rdata;
    #1;
    rdataSeen = bus.dmi_rdata;
    checkOutput("dmi_hit", 32'(bus.dmi_hit), 32'(s.rd && modelHit(s.addr)));
    checkOutput("dmi_rdata", bus.dmi_rdata, s.rd ? modelRead(s.addr) : 32'd0);
    @(posedge clk);
    modelStep(s);
  endtask

  function automatic stim_t mkS(input logic [6:0] a, input logic [31:0] d, input logic wr, input logic rd);
    stim_t s;
    s.rstN = 1; s.active = 1; s.halted = 1; s.avail = 1;
    s.addr = a; s.wdata = d; s.wr = wr; s.rd = rd; s.ack = 0; s.rdata = 0;
    return s;
  endfunction

  function automatic vec_t mkVec(input logic [6:0] a, input logic [31:0] d, input logic wr, input logic rd,
                                 input logic ack, input logic [31:0] rdata, input logic halted,
                                 input logic avail, input logic active, input logic expReq,
                                 input logic [31:0] expRdata);
    vec_t v;
    v.s = mkS(a, d, wr, rd);
    v.s.ack = ack; v.s.rdata = rdata; v.s.halted = halted; v.s.avail = avail; v.s.active = active;
    v.expReq = expReq; v.expRdata = expRdata;
    return v;
  endfunction

  function automatic vec_t vW(input logic [6:0] a, input logic [31:0] d, input logic req);
    return mkVec(a, d, 1, 0, 0, 0, 1, 1, 1, req, 0);
  endfunction

  function automatic vec_t vR(input logic [6:0] a, input logic req, input logic [31:0] exp);
    return mkVec(a, 0, 0, 1, 0, 0, 1, 1, 1, req, exp);
  endfunction

  function automatic vec_t vI(input logic req);
    return mkVec(7'h00, 0, 0, 0, 0, 0, 1, 1, 1, req, 0);
  endfunction

  function automatic logic [31:0] genCmd();
    logic [31:0] w;
    w = 32'd0;
    w[31:24] = ($urandom_range(0, 14) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    w[22:20] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
    w[19]    = ($urandom_range(0, 14) == 0);
    w[18]    = ($urandom_range(0, 14) == 0);
    w[17]    = ($urandom_range(0, 5) != 0);
    w[16]    = 1'($urandom_range(0, 1));
    w[15:0]  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h1000 + 16'($urandom_range(0, 31));
    return w;
  endfunction

  function automatic stim_t genStim();
    stim_t s;
    int unsigned op, pick;
    op = $urandom_range(0, 99);
    pick = $urandom_range(0, 9);
    s = mkS(7'h00, 0, 0, 0);
    if (pick < 3) s.addr = CMD;
    else if (pick < 5) s.addr = ACS;
    else if (pick < 8) s.addr = D0;
    else if (pick == 8) s.addr = AUT;
    else s.addr = 7'($urandom);
    s.wr = (op < 40);
    s.rd = (op >= 40 && op < 65);
    if (s.addr == CMD) s.wdata = genCmd();
    else if (s.addr == ACS) s.wdata = ($urandom_range(0, 1) == 0) ? 32'h700 : $urandom;
    else s.wdata = $urandom;
    s.ack    = mBusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    s.rdata  = $urandom;
    s.halted = ($urandom_range(0, 9) != 0);
    s.avail  = ($urandom_range(0, 29) != 0);
    s.active = ($urandom_range(0, 59) != 0);
    s.rstN   = ($urandom_range(0, 99) != 0);
    return s;
  endfunction

  initial begin
    vec_t        vecs[$];
    stim_t       s;
    logic        req;
    logic [31:0] rd;

    bus.dmi_address = 0; bus.dmi_wdata = 0; bus.dmi_write = 0; bus.dmi_read = 0;
    bus.reg_ack = 0; bus.reg_rdata = 0;
    repeat (2) @(posedge clk);
    modelReset();

    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vR(D0, 0, 32'h0));
    vecs.push_back(vR(CMD, 0, 32'h0));
    vecs.push_back(vW(D0, 32'hDEADBEEF, 0));
    vecs.push_back(vW(CMD, 32'h00231005, 0));
    vecs.push_back(vR(ACS, 1, 32'h1001));
    vecs.push_back(vI(1));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 1, 32'h0, 1, 1, 1, 1, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vW(CMD, 32'h00221007, 0));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 1, 32'h12345678, 1, 1, 1, 1, 0));
    vecs.push_back(vR(D0, 0, 32'h12345678));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(mkVec(CMD, 32'h00221001, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(ACS, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h401));
    vecs.push_back(vW(ACS, 32'h700, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vW(CMD, 32'h00331001, 0));
    vecs.push_back(vR(ACS, 0, 32'h201));
    vecs.push_back(vW(ACS, 32'h200, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vW(CMD, 32'h00231003, 0));
    vecs.push_back(vW(D0, 32'hCAFEF00D, 1));
    vecs.push_back(vR(ACS, 1, 32'h1101));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 1, 32'h0, 1, 1, 1, 1, 0));
    vecs.push_back(vR(D0, 0, 32'h12345678));
    vecs.push_back(vR(ACS, 0, 32'h101));
    vecs.push_back(vW(ACS, 32'h100, 0));
    vecs.push_back(vW(CMD, 32'h00231004, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(vI(1));
    vecs.push_back(vR(ACS, 0, 32'h701));
    vecs.push_back(vW(ACS, 32'h700, 0));
    vecs.push_back(vW(CMD, 32'h00221008, 0));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vR(D0, 0, 32'h0));
    vecs.push_back(vW(CMD, 32'h00221009, 0));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(vR(ACS, 0, 32'h401));
    vecs.push_back(vW(ACS, 32'h700, 0));
    vecs.push_back(vW(CMD, 32'h0022100A, 0));
    vecs.push_back(mkVec(7'h00, 0, 0, 0, 1, 32'h0BADF00D, 1, 0, 1, 1, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vR(D0, 0, 32'h0BADF00D));
    vecs.push_back(vW(CMD, 32'h00221020, 0));
    vecs.push_back(vR(ACS, 0, 32'h201));
    vecs.push_back(vW(ACS, 32'h700, 0));
    vecs.push_back(vW(CMD, 32'h00201000, 0));
    vecs.push_back(vR(ACS, 0, 32'h1));
    vecs.push_back(vW(CMD, 32'h01221001, 0));
    vecs.push_back(vR(ACS, 0, 32'h201));
    vecs.push_back(vW(ACS, 32'h700, 0));
    vecs.push_back(vR(7'h10, 0, 32'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, req, rd);
      checkOutput($sformatf("vec%0d reg_req", i), 32'(req), 32'(vecs[i].expReq));
      if (vecs[i].s.rd) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
    end

    // Register write issue: outputs one cycle after the command, ack on the third access cycle.
    applyStimulus(mkS(D0, 32'hDEADBEEF, 1, 0), req, rd);
    applyStimulus(mkS(CMD, 32'h00231005, 1, 0), req, rd);
    #2;
    checkOutput("wr5 reg_req", 32'(bus.reg_req), 32'd1);
    checkOutput("wr5 reg_write", 32'(bus.reg_write), 32'd1);
    checkOutput("wr5 reg_addr", 32'(bus.reg_addr), 32'd5);
    checkOutput("wr5 reg_wdata", bus.reg_wdata, 32'hDEADBEEF);
    applyStimulus(mkS(7'h00, 0, 0, 0), req, rd);
    applyStimulus(mkS(7'h00, 0, 0, 0), req, rd);
    s = mkS(7'h00, 0, 0, 0); s.ack = 1;
    applyStimulus(s, req, rd);
    #2;
    checkOutput("wr5 req drop", 32'(bus.reg_req), 32'd0);
    applyStimulus(mkS(ACS, 0, 0, 1), req, rd);
    checkOutput("wr5 abstractcs", rd, 32'h1);

`ifdef DM_ABSTRACT_AUTOEXEC_EN
    applyStimulus(mkS(AUT, 32'h1, 1, 0), req, rd);
    applyStimulus(mkS(CMD, 32'h00231002, 1, 0), req, rd);
    s = mkS(7'h00, 0, 0, 0); s.ack = 1;
    applyStimulus(s, req, rd);
    applyStimulus(mkS(D0, 32'h55, 1, 0), req, rd);
    #2;
    checkOutput("auto reg_req", 32'(bus.reg_req), 32'd1);
    checkOutput("auto reg_write", 32'(bus.reg_write), 32'd1);
    checkOutput("auto reg_addr", 32'(bus.reg_addr), 32'd2);
    checkOutput("auto reg_wdata", bus.reg_wdata, 32'h55);
    applyStimulus(s, req, rd);
    applyStimulus(mkS(D0, 0, 0, 1), req, rd);
    checkOutput("auto read data0", rd, 32'h55);
    #2;
    checkOutput("auto read reissue", 32'(bus.reg_req), 32'd1);
    applyStimulus(s, req, rd);
    applyStimulus(mkS(AUT, 32'h0, 1, 0), req, rd);
`endif

    for (int n = 0; n < 1500; n++) begin
      s = genStim();
      applyStimulus(s, req, rd);
    end

    applyStimulus(mkS(7'h00, 0, 0, 0), req, rd);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
